// File: rtl/ulpb_tx_pkg.sv
// ulpb_tx_pkg: shared constants for the ULPB transmit queue.
//   - FSM state encodings used by ulpb_tx_queue.
//   - Bit-field offsets of one queue entry {addr, data, last}:
//     last at bit 0, data just above it, addr in the top bits.
package ulpb_tx_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_ACKLOW  = 3'd2;
    localparam logic [2:0] ST_RESP    = 3'd3;
    localparam logic [2:0] ST_RESPCLR = 3'd4;

    localparam int ENT_LAST_BIT = 0;
    localparam int ENT_DATA_LSB = 1;

    function automatic int ent_addr_lsb(input int data_width);
        return ENT_DATA_LSB + data_width;
    endfunction

endpackage

// File: rtl/ulpb_tx_fifo_mem.sv
// ulpb_tx_fifo_mem: DEPTH x WIDTH register array for queue entries.
// Ports:
//   CLK       clock
//   wr_en     write strobe, wr_entry stored at wr_idx on the rising edge
//   wr_idx    write index
//   wr_entry  entry to store
//   rd_idx    combinational read index
//   rd_entry  entry at rd_idx
//   last_vec  'last' flag of every entry, used to locate a message end
module ulpb_tx_fifo_mem
    import ulpb_tx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 41,
    parameter int AW    = 3
) (
    input  logic             CLK,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_entry,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_entry,
    output logic [DEPTH-1:0] last_vec
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_idx];

    always_comb begin
        last_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            last_vec[i] = mem[i][ENT_LAST_BIT];
        end
    end

endmodule

// File: rtl/ulpb_tx_queue.sv
// ulpb_tx_queue: store-and-forward transmit queue feeding the 32-bit bus node.
// A message (address + 1..N words) launches only once fully committed; failed
// messages are replayed from their first word up to MAX_RETRY times, then the
// result is reported on DONE_VALID/DONE_OK.
// Ports:
//   CLK, RESET (async, active low)
//   WR_EN/WR_ADDR/WR_DATA/WR_LAST  host write side; WR_ADDR taken on first word
//   WR_FULL, WR_ERR                full flag, pulse on dropped/discarded writes
//   DONE_VALID, DONE_OK            per-message completion pulse and result
//   TX_ADDR/TX_DATA/TX_PEND/TX_REQ, TX_ACK        word handshake with node
//   TX_SUCC/TX_FAIL, TX_RESP_ACK                  response handshake with node
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a committed message; loads word at rd_ptr
// ST_REQ     | TX_REQ high with word stable, waiting for TX_ACK
// ST_ACKLOW  | TX_REQ low, waiting for TX_ACK to drop
// ST_RESP    | all words sent, waiting for TX_SUCC or TX_FAIL
// ST_RESPCLR | TX_RESP_ACK high until the node clears its response
module ulpb_tx_queue
    import ulpb_tx_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int MAX_RETRY  = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WR_EN,
    input  logic [ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_LAST,
    output logic                  WR_FULL,
    output logic                  WR_ERR,
    output logic                  DONE_VALID,
    output logic                  DONE_OK,
    output logic [ADDR_WIDTH-1:0] TX_ADDR,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_PEND,
    output logic                  TX_REQ,
    input  logic                  TX_ACK,
    input  logic                  TX_SUCC,
    input  logic                  TX_FAIL,
    output logic                  TX_RESP_ACK
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int PW       = PTR_W + 1;    // extra wrap bit distinguishes full from empty
    localparam int ENTRY_W  = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam int ADDR_LSB = ent_addr_lsb(DATA_WIDTH);
    localparam int RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [2:0]            state;
    logic [PW-1:0]         wr_ptr, commit_ptr, rd_ptr, msg_start, msg_cnt;
    logic [PW-1:0]         rd_ptr_inc, msg_end;
    logic [ADDR_WIDTH-1:0] wr_addr_q, addr_in;
    logic [RW-1:0]         retry_cnt;
    logic                  resp_fail;
    logic [ENTRY_W-1:0]    wr_entry, rd_entry;
    logic [DEPTH-1:0]      last_vec;
    logic [PTR_W-1:0]      rd_idx;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  first_word, wr_accept, overflow, commit;
    logic                  early_fail, resp_clear, retry_ok, relaunch, finish;

    // Occupancy is measured from msg_start: words of the in-flight message stay
    // reserved until it finishes so a retry can replay them.
    assign WR_FULL    = (wr_ptr - msg_start) == PW'(DEPTH);
    assign first_word = (wr_ptr == commit_ptr);
    assign wr_accept  = WR_EN && !WR_FULL;
    assign overflow   = WR_FULL && !first_word;
    assign commit     = wr_accept && WR_LAST;
    assign addr_in    = first_word ? WR_ADDR : wr_addr_q;

    always_comb begin
        wr_entry = '0;
        wr_entry[ENT_LAST_BIT] = WR_LAST;
        wr_entry[ENT_DATA_LSB +: DATA_WIDTH] = WR_DATA;
        wr_entry[ADDR_LSB +: ADDR_WIDTH] = addr_in;
    end

    // ACKLOW pre-reads the following word so it can be presented with TX_REQ.
    assign rd_ptr_inc = rd_ptr + PW'(1);
    assign rd_idx     = (state == ST_ACKLOW) ? rd_ptr_inc[PTR_W-1:0] : rd_ptr[PTR_W-1:0];
    assign rd_addr    = rd_entry[ADDR_LSB +: ADDR_WIDTH];
    assign rd_data    = rd_entry[ENT_DATA_LSB +: DATA_WIDTH];
    assign rd_last    = rd_entry[ENT_LAST_BIT];

    ulpb_tx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (PTR_W)
    ) u_mem (
        .CLK      (CLK),
        .wr_en    (wr_accept),
        .wr_idx   (wr_ptr[PTR_W-1:0]),
        .wr_entry (wr_entry),
        .rd_idx   (rd_idx),
        .rd_entry (rd_entry),
        .last_vec (last_vec)
    );

    // An early fail can abandon a message mid-way, so its end is found by
    // searching forward from msg_start for the first 'last' flag.
    function automatic logic [PTR_W-1:0] ix(input logic [PW-1:0] p);
        return p[PTR_W-1:0];
    endfunction

    always_comb begin
        msg_end = msg_start;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (last_vec[ix(msg_start + PW'(i))]) begin
                msg_end = msg_start + PW'(i);
            end
        end
    end

    assign early_fail = TX_FAIL && ((state == ST_REQ) || (state == ST_ACKLOW));
    assign resp_clear = (state == ST_RESPCLR) && !TX_SUCC && !TX_FAIL;
    assign retry_ok   = int'(retry_cnt) < MAX_RETRY;
    assign relaunch   = resp_clear && resp_fail && retry_ok;
    assign finish     = resp_clear && !relaunch;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            wr_addr_q  <= '0;
            msg_cnt    <= '0;
            WR_ERR     <= 1'b0;
        end else begin
            WR_ERR <= (WR_EN && WR_FULL) || overflow;
            if (overflow) begin
                wr_ptr <= commit_ptr;
            end else if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (commit) begin
                commit_ptr <= wr_ptr + PW'(1);
            end
            if (wr_accept && first_word) begin
                wr_addr_q <= WR_ADDR;
            end
            msg_cnt <= msg_cnt + PW'(commit) - PW'(finish);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            rd_ptr      <= '0;
            msg_start   <= '0;
            retry_cnt   <= '0;
            resp_fail   <= 1'b0;
            TX_ADDR     <= '0;
            TX_DATA     <= '0;
            TX_PEND     <= 1'b0;
            TX_REQ      <= 1'b0;
            TX_RESP_ACK <= 1'b0;
            DONE_VALID  <= 1'b0;
            DONE_OK     <= 1'b0;
        end else begin
            DONE_VALID <= 1'b0;
            DONE_OK    <= 1'b0;
            if (early_fail) begin
                TX_REQ      <= 1'b0;
                TX_RESP_ACK <= 1'b1;
                resp_fail   <= 1'b1;
                state       <= ST_RESPCLR;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (msg_cnt != '0) begin
                            TX_ADDR <= rd_addr;
                            TX_DATA <= rd_data;
                            TX_PEND <= ~rd_last;
                            TX_REQ  <= 1'b1;
                            state   <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (TX_ACK) begin
                            TX_REQ <= 1'b0;
                            state  <= ST_ACKLOW;
                        end
                    end
                    ST_ACKLOW: begin
                        if (!TX_ACK) begin
                            if (TX_PEND) begin
                                rd_ptr  <= rd_ptr_inc;
                                TX_ADDR <= rd_addr;
                                TX_DATA <= rd_data;
                                TX_PEND <= ~rd_last;
                                TX_REQ  <= 1'b1;
                                state   <= ST_REQ;
                            end else begin
                                state <= ST_RESP;
                            end
                        end
                    end
                    ST_RESP: begin
                        if (TX_SUCC || TX_FAIL) begin
                            TX_RESP_ACK <= 1'b1;
                            resp_fail   <= TX_FAIL;
                            state       <= ST_RESPCLR;
                        end
                    end
                    ST_RESPCLR: begin
                        if (resp_clear) begin
                            TX_RESP_ACK <= 1'b0;
                            state       <= ST_IDLE;
                            if (relaunch) begin
                                rd_ptr    <= msg_start;
                                retry_cnt <= retry_cnt + RW'(1);
                            end else begin
                                rd_ptr     <= msg_end + PW'(1);
                                msg_start  <= msg_end + PW'(1);
                                retry_cnt  <= '0;
                                DONE_VALID <= 1'b1;
                                DONE_OK    <= ~resp_fail;
                            end
                        end else if (TX_FAIL) begin
                            resp_fail <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ulpb_tx_queue.sv
module tb_ulpb_tx_queue;

    localparam int DEPTH     = 8;
    localparam int MAX_RETRY = 2;
    localparam int NV        = 8;

    logic        CLK, RESET;
    logic        WR_EN, WR_LAST;
    logic [7:0]  WR_ADDR;
    logic [31:0] WR_DATA;
    logic        WR_FULL, WR_ERR, DONE_VALID, DONE_OK;
    logic [7:0]  TX_ADDR;
    logic [31:0] TX_DATA;
    logic        TX_PEND, TX_REQ, TX_ACK, TX_SUCC, TX_FAIL, TX_RESP_ACK;

    ulpb_tx_queue #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .WR_EN       (WR_EN),
        .WR_ADDR     (WR_ADDR),
        .WR_DATA     (WR_DATA),
        .WR_LAST     (WR_LAST),
        .WR_FULL     (WR_FULL),
        .WR_ERR      (WR_ERR),
        .DONE_VALID  (DONE_VALID),
        .DONE_OK     (DONE_OK),
        .TX_ADDR     (TX_ADDR),
        .TX_DATA     (TX_DATA),
        .TX_PEND     (TX_PEND),
        .TX_REQ      (TX_REQ),
        .TX_ACK      (TX_ACK),
        .TX_SUCC     (TX_SUCC),
        .TX_FAIL     (TX_FAIL),
        .TX_RESP_ACK (TX_RESP_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One message of the vector table: n_fail attempts fail before success
    // (attempts beyond MAX_RETRY never happen); early = fail raised while the
    // second word is requested; both = SUCC and FAIL raised together on fails.
    typedef struct {
        int          n_words;
        logic [7:0]  addr;
        logic [31:0] d0;
        logic [31:0] step_d;
        int          n_fail;
        bit          early;
        bit          both;
        bit          exp_ok;
    } vec_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        pend;
    } word_t;

    vec_t  vecs[NV];
    word_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic host_word(input logic [7:0] wa, input logic [7:0] ea, input logic [31:0] d,
                             input bit last, input bit push);
        word_t w;
        WR_EN = 1'b1; WR_ADDR = wa; WR_DATA = d; WR_LAST = last;
        if (push) begin
            w.addr = ea; w.data = d; w.pend = !last;
            exp_q.push_back(w);
        end
        step();
        WR_EN = 1'b0; WR_LAST = 1'b0;
    endtask

    task automatic host_msg(input vec_t m);
        for (int i = 0; i < m.n_words; i++) begin
            // Non-first words carry a bogus address the queue must ignore.
            host_word((i == 0) ? m.addr : ~m.addr, m.addr, m.d0 + m.step_d * i,
                      i == m.n_words - 1, 1'b1);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (TX_REQ) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_tx_req: TX_REQ still 0 after 40 cycles, required 1");
        end
    endtask

    task automatic respond(input bit fail, input bit both, input bit final_try, input bit exp_ok);
        TX_FAIL = fail;
        TX_SUCC = !fail || both;
        step();
        check("resp_ack_rise", 64'(TX_RESP_ACK), 64'(1));
        step();
        check("resp_ack_hold", 64'(TX_RESP_ACK), 64'(1));
        check("done_early", 64'(DONE_VALID), 64'(0));
        TX_FAIL = 1'b0;
        TX_SUCC = 1'b0;
        step();
        check("resp_ack_clr", 64'(TX_RESP_ACK), 64'(0));
        check("done_valid", 64'(DONE_VALID), 64'(final_try));
        if (final_try) check("done_ok", 64'(DONE_OK), 64'(exp_ok));
        step();
        check("done_pulse_len", 64'(DONE_VALID), 64'(0));
    endtask

    // Node model: serves the message at the head of the scoreboard, replaying
    // attempts as the retry rule dictates, and pops it once finished.
    task automatic serve_msg(input int n_fail_in, input bit early, input bit both, input bit exp_ok);
        int len;
        bit ok, fail_now, final_try;
        len = 0;
        foreach (exp_q[i]) if (len == 0 && !exp_q[i].pend) len = i + 1;
        if (len == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_len: no complete message in scoreboard, size %0d", exp_q.size());
            return;
        end
        for (int a = 0; a <= MAX_RETRY; a++) begin
            fail_now  = (a < n_fail_in);
            final_try = !fail_now || (a == MAX_RETRY);
            for (int w = 0; w < len; w++) begin
                wait_req(ok);
                if (!ok) return;
                check("tx_addr", 64'(TX_ADDR), 64'(exp_q[w].addr));
                check("tx_data", 64'(TX_DATA), 64'(exp_q[w].data));
                check("tx_pend", 64'(TX_PEND), 64'(exp_q[w].pend));
                if (fail_now && early && w == 1) begin
                    TX_FAIL = 1'b1;
                    step();
                    check("early_req_drop", 64'(TX_REQ), 64'(0));
                    check("early_resp_ack", 64'(TX_RESP_ACK), 64'(1));
                    TX_FAIL = 1'b0;
                    step();
                    check("early_resp_clr", 64'(TX_RESP_ACK), 64'(0));
                    check("early_done_valid", 64'(DONE_VALID), 64'(final_try));
                    if (final_try) check("early_done_ok", 64'(DONE_OK), 64'(exp_ok));
                    break;
                end
                TX_ACK = 1'b1;
                step();
                check("req_drop_on_ack", 64'(TX_REQ), 64'(0));
                TX_ACK = 1'b0;
                step();
            end
            if (!(fail_now && early)) respond(fail_now, both, final_try, exp_ok);
            if (final_try) break;
        end
        for (int i = 0; i < len; i++) void'(exp_q.pop_front());
    endtask

    function automatic logic [63:0] outs();
        return {17'd0, TX_REQ, TX_PEND, TX_RESP_ACK, DONE_VALID, DONE_OK, WR_FULL, WR_ERR,
                TX_ADDR, TX_DATA};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit ok;
        vecs[0] = '{1, 8'h5A, 32'hDEADBEEF, 32'h0,  0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{3, 8'h3C, 32'h11,       32'h11, 0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{3, 8'h3C, 32'h11,       32'h11, 2, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{3, 8'h4D, 32'h11,       32'h11, 3, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{2, 8'h77, 32'hA0,       32'h1,  1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1, 8'hFF, 32'h12345678, 32'h0,  0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{2, 8'h66, 32'h5,        32'h5,  3, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1, 8'h01, 32'hCAFEF00D, 32'h0,  0, 1'b0, 1'b0, 1'b1};

        RESET = 1'b0; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0; WR_LAST = 1'b0;
        TX_ACK = 1'b0; TX_SUCC = 1'b0; TX_FAIL = 1'b0;
        repeat (3) step();
        check("reset_outputs", outs(), 64'(0));
        RESET = 1'b1;
        step();

        // No launch before WR_LAST; first TX_REQ two cycles after the last write.
        host_word(8'h21, 8'h21, 32'h11, 1'b0, 1'b1);
        cnt = 0;
        repeat (3) begin
            if (TX_REQ) cnt++;
            step();
        end
        check("no_req_before_last", 64'(cnt), 64'(0));
        host_word(8'hEE, 8'h21, 32'h22, 1'b0, 1'b1);
        host_word(8'hEE, 8'h21, 32'h33, 1'b1, 1'b1);
        check("req_latency_1", 64'(TX_REQ), 64'(0));
        step();
        check("req_latency_2", 64'(TX_REQ), 64'(1));
        serve_msg(0, 1'b0, 1'b0, 1'b1);
        cnt = 0;
        repeat (5) begin
            if (TX_REQ || WR_FULL) cnt++;
            step();
        end
        check("queue_empty_idle", 64'(cnt), 64'(0));

        // Vector table; the next message is queued while the current one is served.
        host_msg(vecs[0]);
        for (int v = 0; v < NV; v++) begin
            if (v + 1 < NV) host_msg(vecs[v + 1]);
            serve_msg(vecs[v].n_fail, vecs[v].early, vecs[v].both, vecs[v].exp_ok);
        end
        check("sb_empty_after_table", 64'(exp_q.size()), 64'(0));

        // Message longer than the queue is discarded.
        for (int i = 0; i < DEPTH; i++) host_word(8'h90, 8'h90, 32'h900 + i, 1'b0, 1'b0);
        check("overflow_full", 64'(WR_FULL), 64'(1));
        step();
        check("overflow_err", 64'(WR_ERR), 64'(1));
        check("overflow_rewind", 64'(WR_FULL), 64'(0));
        step();
        check("overflow_err_pulse", 64'(WR_ERR), 64'(0));
        cnt = 0;
        repeat (5) begin
            if (TX_REQ) cnt++;
            step();
        end
        check("overflow_no_launch", 64'(cnt), 64'(0));
        host_word(8'h33, 8'h33, 32'h0BADF00D, 1'b1, 1'b1);
        serve_msg(0, 1'b0, 1'b0, 1'b1);

        // Queue filled with committed messages, then one extra write is dropped.
        for (int i = 0; i < DEPTH; i++) host_word(8'h80 + 8'(i), 8'h80 + 8'(i), 32'h01010101 * i, 1'b1, 1'b1);
        check("full_flag", 64'(WR_FULL), 64'(1));
        host_word(8'hAA, 8'hAA, 32'hAAAAAAAA, 1'b1, 1'b0);
        check("full_drop_err", 64'(WR_ERR), 64'(1));
        for (int i = 0; i < DEPTH; i++) serve_msg(0, 1'b0, 1'b0, 1'b1);
        check("sb_empty_after_full", 64'(exp_q.size()), 64'(0));
        cnt = 0;
        repeat (5) begin
            if (TX_REQ) cnt++;
            step();
        end
        check("dropped_word_not_sent", 64'(cnt), 64'(0));

        // Reset while a request is outstanding.
        host_word(8'h42, 8'h42, 32'h99, 1'b1, 1'b1);
        wait_req(ok);
        RESET = 1'b0;
        #1;
        check("reset_in_req", outs(), 64'(0));
        #2;
        RESET = 1'b1;
        exp_q.delete();
        cnt = 0;
        repeat (10) begin
            step();
            if (DONE_VALID || TX_REQ) cnt++;
        end
        check("no_done_after_reset", 64'(cnt), 64'(0));
        host_word(8'h5A, 8'h5A, 32'h600DCAFE, 1'b1, 1'b1);
        serve_msg(0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
